// File: rtl/rv32_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pkg
// Shared definitions for the RV32 fetch stage.
//   fetch_state_e    : fetch sequencer state encoding
//   RV32_NOP_INSTR   : canonical NOP (addi x0, x0, 0) shown to decode when empty
//   RV32_INSTR_BYTES : byte distance between consecutive instructions
// -----------------------------------------------------------------------------
package rv32_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    HOLD  = 3'd4
  } fetch_state_e;

  localparam logic [31:0] RV32_NOP_INSTR   = 32'h0000_0013;
  localparam int unsigned RV32_INSTR_BYTES = 32'd4;

endpackage

// File: rtl/rv32_fetch_hold_buf.sv
// -----------------------------------------------------------------------------
// rv32_fetch_hold_buf
// One-entry buffer that parks a fetched instruction while decode is stalled
// and the output register is still occupied.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (empties the buffer)
//   clear      : drop the buffered entry (redirect); wins over load/drain
//   load       : capture load_instr/load_pc, entry becomes valid
//   drain      : entry has been moved out, becomes empty
//   load_instr : instruction to capture
//   load_pc    : PC of the instruction to capture
//   valid      : buffer holds an entry
//   instr      : buffered instruction
//   pc         : PC of the buffered instruction
// -----------------------------------------------------------------------------
module rv32_fetch_hold_buf
  import rv32_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] load_instr,
  input  logic [W-1:0] load_pc,
  output logic         valid,
  output logic [W-1:0] instr,
  output logic [W-1:0] pc
);

  // Entry register: clear beats load beats drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= W'(RV32_NOP_INSTR);
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      instr <= W'(RV32_NOP_INSTR);
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (drain) begin
      valid <= 1'b0;
      instr <= instr;
      pc    <= pc;
    end else begin
      valid <= valid;
      instr <= instr;
      pc    <= pc;
    end
  end

endmodule

// File: rtl/rv32_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// rv32_fetch_sequencer
// Fetch-stage controller: issues instruction-memory requests (one outstanding
// at most), tracks the fetch PC, buffers one instruction while decode stalls,
// and handles branch/trap redirects by discarding any in-flight response.
// Decode sees the canonical NOP whenever no valid instruction is present.
//
// Ports:
//   clk_in          : clock, rising edge
//   rst_in          : synchronous active-high reset
//   imem_req_out    : fetch request valid
//   imem_addr_out   : fetch address (always equals the fetch PC)
//   imem_gnt_in     : request accepted this cycle
//   imem_rvalid_in  : response valid
//   imem_rdata_in   : response instruction
//   stall_in        : decode cannot accept this cycle
//   redirect_in     : redirect request (highest priority)
//   redirect_pc_in  : redirect target (low two bits ignored)
//   instr_out       : instruction to decode, NOP when not valid
//   instr_pc_out    : PC of instr_out
//   instr_valid_out : instr_out holds a real fetched instruction
//   flush_out       : inverse of instr_valid_out, drives decode mux flush
//
// Optional feature macro: RV32_FETCH_PERF_CNT_EN
//   adds fetch_count_out (consumed instructions) and bubble_count_out
//   (cycles without a valid instruction outside reset).
// -----------------------------------------------------------------------------
module rv32_fetch_sequencer
  import rv32_pkg::*;
#(
  parameter int                           INSTRUCTION_WIDTH = 32,
  parameter logic [INSTRUCTION_WIDTH-1:0] RESET_PC          = '0
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  output logic                         imem_req_out,
  output logic [INSTRUCTION_WIDTH-1:0] imem_addr_out,
  input  logic                         imem_gnt_in,
  input  logic                         imem_rvalid_in,
  input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata_in,
  input  logic                         stall_in,
  input  logic                         redirect_in,
  input  logic [INSTRUCTION_WIDTH-1:0] redirect_pc_in,
  output logic [INSTRUCTION_WIDTH-1:0] instr_out,
  output logic [INSTRUCTION_WIDTH-1:0] instr_pc_out,
  output logic                         instr_valid_out,
  output logic                         flush_out
`ifdef RV32_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                  fetch_count_out,
  output logic [31:0]                  bubble_count_out
`endif
);

  localparam int W = INSTRUCTION_WIDTH;
  // Clears the two byte-offset bits of a redirect target.
  localparam logic [W-1:0] ALIGN_MASK = ~W'(3);

  fetch_state_e state, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic [W-1:0] inflight_pc, inflight_pc_d;
  logic         valid_d;
  logic [W-1:0] instr_d;
  logic [W-1:0] instr_pc_d;

  logic         consume;
  logic         out_free;
  logic         pend_load;
  logic         pend_drain;
  logic         pend_clear;
  logic         pend_valid;
  logic [W-1:0] pend_instr;
  logic [W-1:0] pend_pc;

  // Decode takes the presented instruction this cycle.
  assign consume  = instr_valid_out & ~stall_in;
  // The output register can accept a new instruction this cycle.
  assign out_free = ~instr_valid_out | consume;

  rv32_fetch_hold_buf #(
    .W (W)
  ) u_hold_buf (
    .clk        (clk_in),
    .rst        (rst_in),
    .clear      (pend_clear),
    .load       (pend_load),
    .drain      (pend_drain),
    .load_instr (imem_rdata_in),
    .load_pc    (inflight_pc),
    .valid      (pend_valid),
    .instr      (pend_instr),
    .pc         (pend_pc)
  );

  // Next-state, next-PC and output-register update decisions.
  always_comb begin
    state_d       = state;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc;
    valid_d       = instr_valid_out;
    instr_d       = instr_out;
    instr_pc_d    = instr_pc_out;
    pend_load     = 1'b0;
    pend_drain    = 1'b0;
    pend_clear    = 1'b0;

    // A consumed instruction with no replacement leaves a NOP behind.
    if (consume) begin
      valid_d = 1'b0;
      instr_d = W'(RV32_NOP_INSTR);
    end else begin
      valid_d = instr_valid_out;
    end

    if (redirect_in) begin
      // Redirect discards whatever is presented or buffered; the in-flight
      // response (if any) must still be absorbed in DRAIN.
      valid_d    = 1'b0;
      instr_d    = W'(RV32_NOP_INSTR);
      pend_clear = 1'b1;
      pc_d       = redirect_pc_in & ALIGN_MASK;
      case (state)
        IDLE:    state_d = REQ;
        REQ:     state_d = imem_gnt_in    ? DRAIN : REQ;
        WAIT:    state_d = imem_rvalid_in ? REQ   : DRAIN;
        HOLD:    state_d = REQ;
        DRAIN:   state_d = imem_rvalid_in ? REQ   : DRAIN;
        default: state_d = IDLE;
      endcase
    end else begin
      case (state)
        IDLE: begin
          state_d = REQ;
        end
        REQ: begin
          if (imem_gnt_in) begin
            inflight_pc_d = pc_q;
            pc_d          = pc_q + W'(RV32_INSTR_BYTES);
            state_d       = WAIT;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (imem_rvalid_in) begin
            if (out_free) begin
              valid_d    = 1'b1;
              instr_d    = imem_rdata_in;
              instr_pc_d = inflight_pc;
              state_d    = REQ;
            end else begin
              pend_load = 1'b1;
              state_d   = HOLD;
            end
          end else begin
            state_d = WAIT;
          end
        end
        HOLD: begin
          // Output is necessarily valid here; refill it from the buffer.
          if (consume && pend_valid) begin
            valid_d    = 1'b1;
            instr_d    = pend_instr;
            instr_pc_d = pend_pc;
            pend_drain = 1'b1;
            state_d    = REQ;
          end else begin
            state_d = HOLD;
          end
        end
        DRAIN: begin
          state_d = imem_rvalid_in ? REQ : DRAIN;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, PC and registered outputs; request/address follow the next state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state           <= IDLE;
      pc_q            <= RESET_PC;
      inflight_pc     <= '0;
      imem_req_out    <= 1'b0;
      imem_addr_out   <= RESET_PC;
      instr_valid_out <= 1'b0;
      instr_out       <= W'(RV32_NOP_INSTR);
      instr_pc_out    <= '0;
      flush_out       <= 1'b1;
    end else begin
      state           <= state_d;
      pc_q            <= pc_d;
      inflight_pc     <= inflight_pc_d;
      imem_req_out    <= (state_d == REQ);
      imem_addr_out   <= pc_d;
      instr_valid_out <= valid_d;
      instr_out       <= instr_d;
      instr_pc_out    <= instr_pc_d;
      flush_out       <= ~valid_d;
    end
  end

`ifdef RV32_FETCH_PERF_CNT_EN
  // Performance counters; free-running, wrap naturally, ignore redirects.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fetch_count_out  <= 32'd0;
      bubble_count_out <= 32'd0;
    end else begin
      fetch_count_out  <= consume          ? fetch_count_out  + 32'd1 : fetch_count_out;
      bubble_count_out <= ~instr_valid_out ? bubble_count_out + 32'd1 : bubble_count_out;
    end
  end
`endif

endmodule
